// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the inter-stage pipeline register.
//               Holds the skid-mode state encoding, default field widths and
//               the per-stage layout of the packed data payload.
//               Optional feature macro used by the family: PIPE_SKID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Occupancy of a skid-mode stage: nothing held, one beat on the outputs,
    // or one beat on the outputs plus one parked in the skid entry.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    localparam int PIPE_CTRL_W = 8;
    localparam int PIPE_DATA_W = 96;
    localparam int PIPE_PC_W   = 32;
    localparam int PIPE_CNT_W  = 16;

    // Row index of the payload layout table.
    typedef enum logic [1:0] {
        STG_IFID  = 2'd0,
        STG_IDEX  = 2'd1,
        STG_EXMEM = 2'd2,
        STG_MEMWB = 2'd3
    } pipe_stage_e;

    // Column index of the payload layout table.
    localparam int PIPE_F_OPA = 0;  // instruction word / operand A / ALU result
    localparam int PIPE_F_OPB = 1;  // return PC / operand B / store data
    localparam int PIPE_F_AUX = 2;  // immediate / return PC (low 27 bits)
    localparam int PIPE_F_RD  = 3;  // destination register index (5 bits)

    // Bit offset of each field inside in_data_i, one row per stage boundary.
    // Fields a stage does not carry still get an offset so the table stays
    // rectangular; instantiators simply leave those bits at zero.
    localparam int unsigned PIPE_FIELD_OFF [4][4] = '{
        '{0, 32, 64, 91},   // IF/ID
        '{0, 32, 64, 91},   // ID/EX
        '{0, 32, 64, 91},   // EX/MEM
        '{0, 32, 64, 91}    // MEM/WB
    };

    // Offset lookup for instantiators packing the payload.
    function automatic int unsigned pipe_field_off(input pipe_stage_e stg,
                                                   input int          fld);
        return PIPE_FIELD_OFF[stg][fld];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buf
// Description : One-entry skid buffer and occupancy FSM for pipe_stage_reg.
//               Built only when PIPE_SKID_EN is defined. It tells the parent
//               when to load its output register and from where (incoming
//               beat or skid entry); the parent owns the output register.
// Ports       : clk_i, rst_i, flush_i   - clock, sync reset, squash
//               in_valid_i, in_beat_i   - upstream beat {ctrl,data,pc}
//               in_ready_o              - registered ready (plus flush)
//               out_ready_i             - downstream consumes held beat
//               out_valid_o             - output register holds a beat
//               load_o, load_beat_o     - load request for output register
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 136
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_beat_i,
    output logic         in_ready_o,
    input  logic         out_ready_i,
    output logic         out_valid_o,
    output logic         load_o,
    output logic [W-1:0] load_beat_o
);

    pipe_state_e  state_q, state_d;
    logic [W-1:0] skid_q, skid_d;
    logic         w_accept;
    logic         w_consume;

    // Ready depends only on state; flush forces it high so upstream can
    // drain its squashed beat in the same cycle.
    assign in_ready_o  = (state_q != SKID) | flush_i;
    assign out_valid_o = (state_q != EMPTY);
    assign w_accept    = in_valid_i & (state_q != SKID) & ~flush_i;
    assign w_consume   = out_valid_o & out_ready_i;

    always_comb begin
        state_d     = state_q;
        skid_d      = skid_q;
        load_o      = 1'b0;
        load_beat_o = in_beat_i;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (w_accept) begin
                        load_o  = 1'b1;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (w_accept && w_consume) begin
                        load_o = 1'b1;
                    end else if (w_accept) begin
                        // Downstream stalled: park the beat instead.
                        skid_d  = in_beat_i;
                        state_d = SKID;
                    end else if (w_consume) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (w_consume) begin
                        load_o      = 1'b1;
                        load_beat_o = skid_q;
                        state_d     = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            skid_q  <= skid_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Reusable inter-stage pipeline register with valid/ready
//               handshake, synchronous flush, bubble insertion (control field
//               cleared whenever no beat is held) and a saturating stall
//               counter for trace.
//               PIPE_SKID_EN defined   : one-entry skid buffer, registered
//                                        in_ready_o.
//               PIPE_SKID_EN undefined : single register, combinational
//                                        in_ready_o.
// Ports       : clk_i, rst_i, flush_i                - clock, reset, squash
//               in_valid_i/in_ready_o                - upstream handshake
//               in_ctrl_i, in_data_i, in_pc_i        - upstream beat
//               out_valid_o/out_ready_i              - downstream handshake
//               out_ctrl_o, out_data_o, out_pc_o     - held beat
//               stall_cnt_o                          - stalled-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int PC_W   = PIPE_PC_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [PC_W-1:0]   in_pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [PC_W-1:0]   out_pc_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int BEAT_W = CTRL_W + DATA_W + PC_W;

    logic [BEAT_W-1:0] w_in_beat;
    logic [BEAT_W-1:0] w_load_beat;
    logic              w_load;
    logic              w_out_valid;
    logic              w_consume;
    logic              w_stall;

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [PC_W-1:0]   pc_q,   pc_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;

    assign w_in_beat = {in_ctrl_i, in_data_i, in_pc_i};

`ifdef PIPE_SKID_EN
    pipe_skid_buf #(
        .W (BEAT_W)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_beat_i   (w_in_beat),
        .in_ready_o  (in_ready_o),
        .out_ready_i (out_ready_i),
        .out_valid_o (w_out_valid),
        .load_o      (w_load),
        .load_beat_o (w_load_beat)
    );
`else
    logic valid_q, valid_d;
    logic w_accept;

    // Room exists when empty or when the held beat leaves this cycle.
    assign in_ready_o  = flush_i | ~valid_q | out_ready_i;
    assign w_accept    = in_valid_i & in_ready_o & ~flush_i;
    assign w_load      = w_accept;
    assign w_load_beat = w_in_beat;
    assign w_out_valid = valid_q;

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (w_accept) begin
            valid_d = 1'b1;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end
`endif

    assign w_consume = w_out_valid & out_ready_i;
    assign w_stall   = w_out_valid & ~out_ready_i & ~flush_i;

    // Control is cleared whenever the stage goes empty so downstream never
    // sees write enables on a bubble; data and PC keep their last values.
    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        pc_d   = pc_q;
        if (flush_i) begin
            ctrl_d = '0;
        end else if (w_load) begin
            {ctrl_d, data_d, pc_d} = w_load_beat;
        end else if (w_consume) begin
            ctrl_d = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (w_stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q <= '0;
            data_q <= '0;
            pc_q   <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid_o = w_out_valid;
    assign out_ctrl_o  = ctrl_q;
    assign out_data_o  = data_q;
    assign out_pc_o    = pc_q;
    assign stall_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg. A queue model of the
//               stage occupancy predicts every output each cycle; directed
//               literal checks pin the reset, throughput, stall, flush,
//               bubble and saturation behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 96;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 4;
`ifdef PIPE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_stage_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_ctrl_i   (in_ctrl),
        .in_data_i   (in_data),
        .in_pc_i     (in_pc),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_ctrl_o  (out_ctrl),
        .out_data_o  (out_data),
        .out_pc_o    (out_pc),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: beats held in order ----------------
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
    } beat_t;

    beat_t             mq[$];
    logic [DATA_W-1:0] m_data = '0;
    logic [PC_W-1:0]   m_pc   = '0;
    int                m_cnt  = 0;
    bit                chk_en = 1'b0;

    function automatic bit model_ready();
        if (flush) return 1'b1;
        if (DEPTH == 2) return (mq.size() < 2);
        return (mq.size() == 0) || out_ready;
    endfunction

    always @(posedge clk) begin
        bit    acc, v, cons;
        beat_t b;
        acc = in_valid && model_ready();
        v   = (mq.size() > 0);
        cons = v && out_ready;
        if (rst) begin
            mq.delete();
            m_data = '0;
            m_pc   = '0;
            m_cnt  = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (v && !out_ready && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (cons) void'(mq.pop_front());
            if (acc) begin
                b.ctrl = in_ctrl;
                b.data = in_data;
                b.pc   = in_pc;
                mq.push_back(b);
            end
            if (mq.size() > 0) begin
                m_data = mq[0].data;
                m_pc   = mq[0].pc;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready",  128'(in_ready),  128'(model_ready()));
            chk("m_out_valid", 128'(out_valid), 128'(mq.size() > 0));
            chk("m_out_ctrl",  128'(out_ctrl),  128'((mq.size() > 0) ? mq[0].ctrl : '0));
            chk("m_out_data",  128'(out_data),  128'(m_data));
            chk("m_out_pc",    128'(out_pc),    128'(m_pc));
            chk("m_stall_cnt", 128'(stall_cnt), 128'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] d, input logic [PC_W-1:0] p);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
        in_pc    = p;
    endtask

    localparam logic [DATA_W-1:0] D_BUB = 96'hB0B0_0000_1111_2222_3333_4444;
    localparam logic [DATA_W-1:0] D_A   = 96'hAAAA_0000_0000_0000_0000_0001;
    localparam logic [DATA_W-1:0] D_B   = 96'hBBBB_0000_0000_0000_0000_0002;
    localparam logic [DATA_W-1:0] D_C   = 96'hCCCC_0000_0000_0000_0000_0003;

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        put(1'b0, '0, '0, '0);
        cyc();
        cyc();
        chk_en = 1'b1;
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_pc",    128'(out_pc),    128'(0));
        chk("rst_cnt",   128'(stall_cnt), 128'(0));
        chk("rst_ready", 128'(in_ready),  128'(1));
        rst = 1'b0;

        // Back-to-back, one beat per cycle with no bubbles.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, CTRL_W'(i + 1), DATA_W'(i * 3 + 7), 32'h100 + 32'(4 * i));
            cyc();
            chk("b2b_pc",    128'(out_pc),    128'(32'h100 + 32'(4 * i)));
            chk("b2b_valid", 128'(out_valid), 128'(1));
        end

        // Bubble: control cleared, data held.
        put(1'b1, 8'hFF, D_BUB, 32'h180);
        cyc();
        chk("bub_ctrl_in", 128'(out_ctrl), 128'(8'hFF));
        in_valid = 1'b0;
        cyc();
        chk("bub_valid", 128'(out_valid), 128'(0));
        chk("bub_ctrl",  128'(out_ctrl),  128'(8'h00));
        chk("bub_data",  128'(out_data),  128'(D_BUB));
        chk("bub_pc",    128'(out_pc),    128'(32'h180));

        // Stall three cycles with a beat held; second beat offered meanwhile.
        out_ready = 1'b0;
        put(1'b1, 8'h5A, D_A, 32'h200);
        cyc();
        chk("stl_pc0",  128'(out_pc),    128'(32'h200));
        chk("stl_cnt0", 128'(stall_cnt), 128'(0));
`ifdef PIPE_SKID_EN
        chk("stl_rdy0", 128'(in_ready), 128'(1));
`else
        chk("stl_rdy0", 128'(in_ready), 128'(0));
`endif
        put(1'b1, 8'h3C, D_B, 32'h204);
        cyc();
        chk("stl_cnt1", 128'(stall_cnt), 128'(1));
        chk("stl_rdy1", 128'(in_ready),  128'(0));
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("stl_cnt3", 128'(stall_cnt), 128'(3));
        chk("stl_pc3",  128'(out_pc),    128'(32'h200));
        chk("stl_ctrl", 128'(out_ctrl),  128'(8'h5A));
        chk("stl_data", 128'(out_data),  128'(D_A));

        // Flush during the stall, with a third beat offered.
        put(1'b1, 8'hC3, D_C, 32'h208);
        flush = 1'b1;
        #1;
        chk("fl_rdy_hi", 128'(in_ready), 128'(1));
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fl_valid", 128'(out_valid), 128'(0));
        chk("fl_ctrl",  128'(out_ctrl),  128'(0));
        chk("fl_ready", 128'(in_ready),  128'(1));
        chk("fl_cnt",   128'(stall_cnt), 128'(3));
        out_ready = 1'b1;
        cyc();
        cyc();
        chk("fl_gone_v",  128'(out_valid), 128'(0));
        chk("fl_gone_pc", 128'(out_pc),    128'(32'h200));

        // Reset while a beat is held.
        out_ready = 1'b0;
        put(1'b1, 8'hA5, D_B, 32'h300);
        cyc();
        in_valid = 1'b0;
        chk("mr_valid0", 128'(out_valid), 128'(1));
        chk("mr_ctrl0",  128'(out_ctrl),  128'(8'hA5));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("mr_valid", 128'(out_valid), 128'(0));
        chk("mr_ctrl",  128'(out_ctrl),  128'(0));
        chk("mr_data",  128'(out_data),  128'(0));
        chk("mr_pc",    128'(out_pc),    128'(0));
        chk("mr_cnt",   128'(stall_cnt), 128'(0));
        chk("mr_ready", 128'(in_ready),  128'(1));

        // Saturation of the 4-bit stall counter.
        put(1'b1, 8'h11, D_C, 32'h400);
        cyc();
        in_valid = 1'b0;
        repeat (20) cyc();
        chk("sat_cnt", 128'(stall_cnt), 128'(4'hF));
        out_ready = 1'b1;
        cyc();
        chk("sat_valid", 128'(out_valid), 128'(0));
        chk("sat_hold",  128'(stall_cnt), 128'(4'hF));

        // Mixed handshake pattern checked by the model only.
        for (int i = 0; i < 48; i++) begin
            put((i % 3) != 2, CTRL_W'(i + 8'h40),
                DATA_W'({32'(i), ~32'(i), 32'(i * 7)}), 32'h800 + 32'(4 * i));
            out_ready = (i % 4) != 1 && (i % 7) != 3;
            flush     = (i == 17) || (i == 33);
            cyc();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the trace-enabled CPU pipeline, replacing the fixed per-stage register banks (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. Carries a control field, a data payload and the instruction PC across one clock. Adds a valid/ready handshake for stalls, a synchronous flush for branch/exception squashing, bubble insertion with control-field clearing, and a saturating stall counter for trace.

## Interface
- `CTRL_W`, default 8: width of control field (write enables, selects); zeroed on every bubble.
- `DATA_W`, default 96: width of data payload (ALU result, store data, return PC, dest reg, packed by instantiator).
- `PC_W`, default 32: width of the trace PC field.
- `CNT_W`, default 16: width of the stall counter.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  squash held and incoming beats this cycle.
- `in_valid_i`  in  1  upstream beat present.
- `in_ready_o`  out  1  block accepts a beat this cycle.
- `in_ctrl_i`  in  CTRL_W  upstream control field.
- `in_data_i`  in  DATA_W  upstream payload.
- `in_pc_i`  in  PC_W  upstream instruction PC.
- `out_valid_o`  out  1  downstream beat present.
- `out_ready_i`  in  1  downstream consumes the beat this cycle.
- `out_ctrl_o`  out  CTRL_W  control field; all-zero whenever `out_valid_o`=0.
- `out_data_o`  out  DATA_W  payload; holds its last value during a bubble.
- `out_pc_o`  out  PC_W  PC of the held beat.
- `stall_cnt_o`  out  CNT_W  saturating count of stalled cycles.

## Operation
- Accept: `in_valid_i && in_ready_o`. Consume: `out_valid_o && out_ready_i`.
- Default mode (no skid): `in_ready_o = !out_valid_o || out_ready_i`, combinational. An accepted beat loads ctrl/data/pc and sets `out_valid_o`. If the held beat is consumed and nothing is accepted, `out_valid_o` clears and `out_ctrl_o` is forced to 0. Data and PC are held.
- Stall: `out_valid_o && !out_ready_i` holds every output unchanged and increments `stall_cnt_o`. The counter saturates at all-ones and does not wrap.
- Flush: priority below reset, above all else. Next cycle `out_valid_o`=0 and `out_ctrl_o`=0, and any skid entry is dropped. `in_ready_o` is forced to 1 while `flush_i`=1, and a beat offered that cycle is discarded. `stall_cnt_o` is not incremented during a flush cycle.
- Reset: `out_valid_o`=0, `out_ctrl_o`=0, `out_data_o`=0, `out_pc_o`=0, `stall_cnt_o`=0. The FSM (skid mode) goes to EMPTY. `in_ready_o`=1 in both modes after reset.
- Simultaneous consume and accept in the same cycle: the new beat replaces the old one with no bubble.

## Timing
- Latency 1 cycle: a beat accepted at edge N is presented on `out_*` after edge N.
- Throughput 1 beat/cycle sustained in both modes.
- Default mode has a combinational path `out_ready_i` -> `in_ready_o`. There is no combinational path from `in_*` to `out_*`.
- Skid mode: `in_ready_o` is a registered output. FSM states and transitions:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on consume without accept.
  - FULL -> SKID on accept without consume.
  - SKID -> FULL on consume; the skid entry moves to the output.
  - `in_ready_o` = (state != SKID).
  - Any state -> EMPTY on flush or reset.

## Configuration
- `PIPE_SKID_EN` defined: adds the one-entry skid buffer and the FSM described above, so `in_ready_o` is registered, breaking the backward ready chain across stages. In the SKID state, one beat accepted while stalled is retained.
- `PIPE_SKID_EN` undefined: single register with the combinational ready described above. No skid storage is built.

## Structure
- Shared package `pipe_pkg`:
  - state enum `pipe_state_e` {EMPTY, FULL, SKID};
  - default width constants `PIPE_CTRL_W`, `PIPE_DATA_W`, `PIPE_PC_W`, `PIPE_CNT_W`;
  - a per-stage localparam offset table used by instantiators to pack fields into `in_data_i`.
- One sub-module, `pipe_skid_buf`: the one-entry holding register plus FSM. It is instantiated only under `PIPE_SKID_EN`.

## Test plan
- Reset mid-stream: `rst_i`=1 for one cycle while `out_valid_o`=1, ctrl=8'hA5 -> next cycle all outputs 0, `in_ready_o`=1.
- Back-to-back: 4 beats with PC 0x100, 0x104, 0x108, 0x10C, `out_ready_i`=1 throughout -> same PCs on `out_pc_o` on 4 consecutive cycles, each 1 cycle after its input, no bubbles.
- Stall: `out_ready_i`=0 for 3 cycles with a beat held -> outputs frozen and `stall_cnt_o` 0->3. In skid mode, `in_ready_o` drops one cycle after the second accept.
- Flush during stall (skid mode, state SKID): `flush_i`=1 -> next cycle `out_valid_o`=0, `out_ctrl_o`=0, `in_ready_o`=1, and neither squashed beat ever appears on `out_*`.
- Bubble: beat with ctrl=8'hFF consumed, no new input -> `out_valid_o`=0, `out_ctrl_o`=8'h00, `out_data_o` unchanged.
- Saturation: with `CNT_W`=4, stall for 20 cycles -> `stall_cnt_o` stops at 4'hF.
